dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 40 ++++
 rtl/dmem_ld_tracker.sv | 77 +++++++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, command/state encodings and the issue-register packet for the
// data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 4;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_command_e;

    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_BUSY = 1'b1
    } iss_state_e;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_ISSUE   = 2'd1,
        LD_WAIT    = 2'd2,
        LD_DISCARD = 2'd3
    } ld_state_e;

    typedef struct packed {
        mem_command_e      cmd;
        logic [XLEN-1:0]   addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        size;
    } dmem_req_t;

    // Tag 0 means "no data", so it can never match an outstanding load.
    function automatic logic tag_hit(input logic [TAG_W-1:0] seen,
                                     input logic [TAG_W-1:0] held);
        return (seen != '0) && (seen == held);
    endfunction

endpackage

// File: rtl/dmem_ld_tracker.sv
// Tracks the single outstanding load from grant through tag return, including
// squash handling, and registers the load response.
module dmem_ld_tracker
    import dmem_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_grant_i,
    input  logic              squash_i,
    input  logic [TAG_W-1:0]  mem2proc_response_i,
    input  logic [TAG_W-1:0]  mem2proc_tag_i,
    input  logic [DATA_W-1:0] mem2proc_data_i,
    output logic              ld_idle_o,
    output logic              ld_kill_o,
    output logic              ld_resp_valid_o,
    output logic [DATA_W-1:0] ld_resp_data_o
);

    ld_state_e         state_q;
    logic [TAG_W-1:0]  tag_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              accept;
    logic              hit;

    // LD_ISSUE implies the issue register holds this load.
    assign accept    = (state_q == LD_ISSUE) && (mem2proc_response_i != '0);
    assign hit       = tag_hit(mem2proc_tag_i, tag_q);
    assign ld_idle_o = (state_q == LD_IDLE);
    assign ld_kill_o = (state_q == LD_ISSUE) && squash_i && !accept;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LD_IDLE;
            tag_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    if (ld_grant_i) state_q <= LD_ISSUE;
                end
                LD_ISSUE: begin
                    if (accept) begin
                        tag_q   <= mem2proc_response_i;
                        state_q <= squash_i ? LD_DISCARD : LD_WAIT;
                    end else if (squash_i) begin
                        state_q <= LD_IDLE;
                    end
                end
                LD_WAIT: begin
                    if (hit) begin
                        state_q <= LD_IDLE;
                        // Data for a load squashed in the return cycle is dropped.
                        if (!squash_i) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= mem2proc_data_i;
                        end
                    end else if (squash_i) begin
                        state_q <= LD_DISCARD;
                    end
                end
                LD_DISCARD: begin
                    if (hit) state_q <= LD_IDLE;
                end
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    assign ld_resp_valid_o = resp_valid_q;
    assign ld_resp_data_o  = resp_data_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates committed stores and speculative loads onto a single-command memory
// port through a one-entry issue register.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              st_req_valid,
    input  logic [XLEN-1:0]   st_req_addr,
    input  logic [DATA_W-1:0] st_req_data,
    input  logic [1:0]        st_req_size,
    input  logic              st_urgent,
    output logic              st_req_ready,
    output logic              st_done,
    input  logic              ld_req_valid,
    input  logic [XLEN-1:0]   ld_req_addr,
    input  logic [1:0]        ld_req_size,
    output logic              ld_req_ready,
    output logic              ld_resp_valid,
    output logic [DATA_W-1:0] ld_resp_data,
    input  logic              squash,
    output logic [1:0]        proc2mem_command,
    output logic [XLEN-1:0]   proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    output logic [1:0]        proc2mem_size,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [DATA_W-1:0] mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag
);

    iss_state_e        iss_state_q, iss_state_d;
    dmem_req_t         issue_q, issue_d;
    dmem_req_t         issue_out;
    logic              last_grant_q, last_grant_d;  // 1 = store granted last
    logic              mem_accept, slot_free;
    logic              st_elig, ld_elig;
    logic              grant_st, grant_ld;
    logic              ld_idle, ld_kill, ld_resp_valid_int;
    logic [DATA_W-1:0] ld_resp_data_int;

    assign mem_accept = (iss_state_q == ISS_BUSY) && (mem2proc_response != '0);
    assign slot_free  = (iss_state_q == ISS_IDLE) || mem_accept;
    assign st_elig    = slot_free && st_req_valid;
    assign ld_elig    = slot_free && ld_idle && !squash && ld_req_valid;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        grant_st = 1'b0;
        grant_ld = 1'b0;
        if (st_elig && ld_elig) begin
            if (st_urgent || !last_grant_q) grant_st = 1'b1;
            else                            grant_ld = 1'b1;
        end else begin
            grant_st = st_elig;
            grant_ld = ld_elig;
        end
    end

    always_comb begin
        iss_state_d  = iss_state_q;
        issue_d      = issue_q;
        last_grant_d = last_grant_q;
        if (mem_accept || ld_kill) begin
            iss_state_d = ISS_IDLE;
            issue_d     = '0;
        end
        // A grant in the accept cycle refills the slot back-to-back.
        if (grant_st) begin
            iss_state_d  = ISS_BUSY;
            issue_d      = '{cmd: MEM_STORE, addr: st_req_addr,
                             data: st_req_data, size: st_req_size};
            last_grant_d = 1'b1;
        end else if (grant_ld) begin
            iss_state_d  = ISS_BUSY;
            issue_d      = '{cmd: MEM_LOAD, addr: ld_req_addr,
                             data: '0, size: ld_req_size};
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            iss_state_q  <= ISS_IDLE;
            issue_q      <= '0;
            last_grant_q <= 1'b0;
        end else begin
            iss_state_q  <= iss_state_d;
            issue_q      <= issue_d;
            last_grant_q <= last_grant_d;
        end
    end

    dmem_ld_tracker u_ld_tracker (
        .clock               (clock),
        .reset               (reset),
        .ld_grant_i          (grant_ld),
        .squash_i            (squash),
        .mem2proc_response_i (mem2proc_response),
        .mem2proc_tag_i      (mem2proc_tag),
        .mem2proc_data_i     (mem2proc_data),
        .ld_idle_o           (ld_idle),
        .ld_kill_o           (ld_kill),
        .ld_resp_valid_o     (ld_resp_valid_int),
        .ld_resp_data_o      (ld_resp_data_int)
    );

    // Outputs read as idle during the reset cycle itself, before state clears.
    assign issue_out        = reset ? '0 : issue_q;
    assign proc2mem_command = issue_out.cmd;
    assign proc2mem_addr    = issue_out.addr;
    assign proc2mem_data    = issue_out.data;
    assign proc2mem_size    = issue_out.size;

    assign st_req_ready  = !reset && grant_st;
    assign ld_req_ready  = !reset && grant_ld;
    assign st_done       = !reset && mem_accept && (issue_q.cmd == MEM_STORE);
    assign ld_resp_valid = !reset && ld_resp_valid_int;
    assign ld_resp_data  = ld_resp_data_int;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed cycle-by-cycle bench for dmem_arbiter; load responses are checked
// against a scoreboard queue filled when matching tags are driven.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              st_req_valid, st_urgent, st_req_ready, st_done;
    logic [31:0]       st_req_addr;
    logic [63:0]       st_req_data;
    logic [1:0]        st_req_size;
    logic              ld_req_valid, ld_req_ready, ld_resp_valid;
    logic [31:0]       ld_req_addr;
    logic [1:0]        ld_req_size;
    logic [63:0]       ld_resp_data;
    logic              squash;
    logic [1:0]        proc2mem_command, proc2mem_size;
    logic [31:0]       proc2mem_addr;
    logic [63:0]       proc2mem_data;
    logic [3:0]        mem2proc_response, mem2proc_tag;
    logic [63:0]       mem2proc_data;

    int                tests_run    = 0;
    int                tests_failed = 0;
    logic [63:0]       exp_ld_q[$];
    logic              resp_due  = 1'b0;
    logic              resp_next = 1'b0;
    logic [1:0]        exp_cmd;

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .st_req_valid      (st_req_valid),
        .st_req_addr       (st_req_addr),
        .st_req_data       (st_req_data),
        .st_req_size       (st_req_size),
        .st_urgent         (st_urgent),
        .st_req_ready      (st_req_ready),
        .st_done           (st_done),
        .ld_req_valid      (ld_req_valid),
        .ld_req_addr       (ld_req_addr),
        .ld_req_size       (ld_req_size),
        .ld_req_ready      (ld_req_ready),
        .ld_resp_valid     (ld_resp_valid),
        .ld_resp_data      (ld_resp_data),
        .squash            (squash),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Step just past the next rising edge; pulse-type inputs default low.
    task automatic tick();
        @(posedge clock);
        #1;
        resp_due          = resp_next;
        resp_next         = 1'b0;
        reset             = 1'b0;
        st_req_valid      = 1'b0;
        ld_req_valid      = 1'b0;
        st_urgent         = 1'b0;
        squash            = 1'b0;
        mem2proc_response = '0;
        mem2proc_tag      = '0;
    endtask

    task automatic observe();
        check("ld_resp_valid", ld_resp_valid, resp_due);
        if (resp_due) begin
            if (exp_ld_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL ld_resp_data: response due, scoreboard empty");
            end else begin
                check("ld_resp_data", ld_resp_data, exp_ld_q.pop_front());
            end
        end
    endtask

    task automatic settle();
        #2;
        observe();
    endtask

    task automatic ret_tag(input logic [3:0] t, input logic [63:0] d, input bit deliver);
        mem2proc_tag  = t;
        mem2proc_data = d;
        if (deliver) begin
            exp_ld_q.push_back(d);
            resp_next = 1'b1;
        end
    endtask

    // One reset cycle with requests and a memory response present; all must be masked.
    task automatic do_reset();
        tick();
        reset             = 1'b1;
        st_req_valid      = 1'b1;
        ld_req_valid      = 1'b1;
        mem2proc_response = 4'd1;
        settle();
        check("rst_cmd", proc2mem_command, MEM_NONE);
        check("rst_addr", proc2mem_addr, 0);
        check("rst_data", proc2mem_data, 0);
        check("rst_size", proc2mem_size, 0);
        check("rst_st_ready", st_req_ready, 0);
        check("rst_ld_ready", ld_req_ready, 0);
        check("rst_st_done", st_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        st_req_valid = 1'b0; st_req_addr = '0; st_req_data = '0; st_req_size = '0;
        st_urgent = 1'b0; ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_size = '0;
        squash = 1'b0; mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
        do_reset();

        // Store accepted on first try.
        tick(); st_req_valid = 1'b1; st_req_addr = 32'h1000; st_req_data = 64'hAA;
        st_req_size = 2'd3; settle();
        check("a_st_ready", st_req_ready, 1);
        check("a_ld_ready", ld_req_ready, 0);
        check("a_cmd_idle", proc2mem_command, MEM_NONE);
        tick(); mem2proc_response = 4'd3; settle();
        check("a_cmd", proc2mem_command, MEM_STORE);
        check("a_addr", proc2mem_addr, 32'h1000);
        check("a_data", proc2mem_data, 64'hAA);
        check("a_size", proc2mem_size, 3);
        check("a_st_done", st_done, 1);
        tick(); settle();
        check("a_cmd_after", proc2mem_command, MEM_NONE);
        check("a_done_after", st_done, 0);

        // Load retried twice, accepted with tag 5, data 4 cycles later.
        tick(); ld_req_valid = 1'b1; ld_req_addr = 32'h2000; ld_req_size = 2'd2; settle();
        check("b_ld_ready", ld_req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); mem2proc_response = (i == 2) ? 4'd5 : 4'd0; settle();
            check("b_cmd_held", proc2mem_command, MEM_LOAD);
            check("b_addr", proc2mem_addr, 32'h2000);
            check("b_data_zero", proc2mem_data, 0);
            check("b_st_done", st_done, 0);
        end
        tick(); settle();
        check("b_cmd_idle", proc2mem_command, MEM_NONE);
        tick(); ld_req_valid = 1'b1; ld_req_addr = 32'h2040; ret_tag(4'd3, 64'hBAD, 0); settle();
        check("b_blocked_wait", ld_req_ready, 0);
        tick(); ld_req_valid = 1'b1; settle();
        check("b_blocked_wait2", ld_req_ready, 0);
        tick(); ld_req_valid = 1'b1; ret_tag(4'd5, 64'hDEAD, 1); settle();
        check("b_blocked_tag_cycle", ld_req_ready, 0);
        tick(); ld_req_valid = 1'b1; settle();
        check("b_next_grant", ld_req_ready, 1);
        tick(); mem2proc_response = 4'd6; settle();
        check("b2_cmd", proc2mem_command, MEM_LOAD);
        check("b2_addr", proc2mem_addr, 32'h2040);
        tick(); ret_tag(4'd6, 64'hBEEF, 1); settle();
        tick(); settle();

        // Both requesting, memory accepts every other cycle: strict alternation.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick();
            st_req_valid = 1'b1; st_req_addr = 32'h4000 + c; st_req_data = 64'h100 + c;
            ld_req_valid = 1'b1; ld_req_addr = 32'h5000 + c;
            mem2proc_response = (c % 2 == 0) ? 4'd1 : 4'd0;
            if (c >= 5 && c % 4 == 1) ret_tag(4'd1, 64'h5A00 + c, 1);
            settle();
            exp_cmd = (c == 0) ? MEM_NONE : ((((c - 1) / 2) % 2 == 0) ? MEM_STORE : MEM_LOAD);
            check("c_st_ready", st_req_ready, (c % 4 == 0));
            check("c_ld_ready", ld_req_ready, (c % 4 == 2));
            check("c_st_done", st_done, (c >= 2 && c % 4 == 2));
            check("c_cmd", proc2mem_command, exp_cmd);
        end

        // Urgent store queue starves loads.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick();
            st_req_valid = 1'b1; ld_req_valid = 1'b1; st_urgent = 1'b1;
            mem2proc_response = (c % 2 == 0) ? 4'd2 : 4'd0;
            settle();
            check("u_st_ready", st_req_ready, (c % 2 == 0));
            check("u_ld_ready", ld_req_ready, 0);
        end

        // Squash while waiting, in issue, on accept, and with a store in flight.
        do_reset();
        tick(); ld_req_valid = 1'b1; ld_req_addr = 32'h3000; settle();
        check("d_ld_ready", ld_req_ready, 1);
        tick(); mem2proc_response = 4'd7; settle();
        check("d_cmd", proc2mem_command, MEM_LOAD);
        tick(); squash = 1'b1; ld_req_valid = 1'b1; ld_req_addr = 32'h3100; settle();
        check("d_squash_blocks", ld_req_ready, 0);
        tick(); ld_req_valid = 1'b1; ret_tag(4'd7, 64'h77, 0); settle();
        check("d_discard_blocks", ld_req_ready, 0);
        tick(); ld_req_valid = 1'b1; settle();
        check("d_regrant", ld_req_ready, 1);
        tick(); squash = 1'b1; settle();
        check("d_kill_cmd", proc2mem_command, MEM_LOAD);
        check("d_kill_addr", proc2mem_addr, 32'h3100);
        tick(); st_req_valid = 1'b1; st_req_addr = 32'h6000; st_req_data = 64'h66;
        st_req_size = 2'd1; settle();
        check("d_killed_cmd", proc2mem_command, MEM_NONE);
        check("d_killed_addr", proc2mem_addr, 0);
        check("d_st_ready", st_req_ready, 1);
        tick(); squash = 1'b1; settle();
        check("d_st_survives", proc2mem_command, MEM_STORE);
        tick(); mem2proc_response = 4'd2; settle();
        check("d_st_cmd", proc2mem_command, MEM_STORE);
        check("d_st_done", st_done, 1);
        tick(); ld_req_valid = 1'b1; ld_req_addr = 32'h3200; settle();
        check("d_ld2_ready", ld_req_ready, 1);
        tick(); mem2proc_response = 4'd4; squash = 1'b1; settle();
        check("d_ld2_cmd", proc2mem_command, MEM_LOAD);
        tick(); ld_req_valid = 1'b1; ret_tag(4'd4, 64'h44, 0); settle();
        check("d_disc2_blocks", ld_req_ready, 0);
        tick(); ld_req_valid = 1'b1; settle();
        check("d_regrant2", ld_req_ready, 1);

        // Reset while a tag is outstanding; the late return is ignored.
        do_reset();
        tick(); ld_req_valid = 1'b1; ld_req_addr = 32'h7000; settle();
        check("e_ld_ready", ld_req_ready, 1);
        tick(); mem2proc_response = 4'd2; settle();
        check("e_cmd", proc2mem_command, MEM_LOAD);
        do_reset();
        tick(); ret_tag(4'd2, 64'h22, 0); settle();
        check("e_cmd_after_rst", proc2mem_command, MEM_NONE);
        tick(); ld_req_valid = 1'b1; ld_req_addr = 32'h7100; settle();
        check("e_ld_ready_after", ld_req_ready, 1);
        tick(); settle();
        check("e_cmd_new", proc2mem_command, MEM_LOAD);

        check("sb_drained", exp_ld_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
